goods_pio_irq_ctrl: RTL

//  Hardware servicer for the 3-bit goods-select input PIO (Avalon-MM slave with edge capture and IRQ).

---
 rtl/goods_pio_pkg.sv | 23 ++
 rtl/goods_sel_arb.sv | 88 ++++++++
 rtl/goods_pio_irq_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/goods_pio_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// goods_pio_pkg: PIO register map and bus-servicer FSM states. Rev 1.0
// ---------------------------------------------------------------------------
package goods_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_CAP  = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CFG     = 3'd1,
    WAIT    = 3'd2,
    RD_CAP  = 3'd3,
    RD_CAP2 = 3'd4,
    CLR     = 3'd5,
    RD_LVL  = 3'd6,
    RD_LVL2 = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/goods_sel_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// goods_sel_arb: pending goods buttons -> one-at-a-time valid/ready stream.
// Build option GOODS_PIO_RR_ARB_EN selects round-robin instead of lowest-first. Rev 1.0
// ---------------------------------------------------------------------------
module goods_sel_arb
  import goods_pio_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             merge_i,
  input  logic [WIDTH-1:0] cap_i,
  input  logic             sel_ready_i,
  output logic             sel_valid_o,
  output logic [IDW-1:0]   sel_id_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] clr;
  logic             valid_q;
  logic [IDW-1:0]   id_q;
  logic             overrun_q;
  logic             accept;
  logic [IDW-1:0]   pick;

  assign accept    = valid_q && sel_ready_i;
  assign clr       = accept ? (WIDTH'(1) << id_q) : '0;
  // OR-ing the merge after the clear lets a recapture of the granted bit survive.
  assign pending_d = (pending_q & ~clr) | (merge_i ? cap_i : '0);

`ifdef GOODS_PIO_RR_ARB_EN
  logic [IDW-1:0]   ptr_q;
  logic [WIDTH-1:0] rot;
  int               off;

  always_comb begin
    rot = WIDTH'({pending_q, pending_q} >> (int'(ptr_q) + 1));
    off = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    pick = IDW'((int'(ptr_q) + 1 + off) % WIDTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IDW'(WIDTH - 1);
    end else if (!valid_q && (pending_q != '0)) begin
      ptr_q <= pick;
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) pick = IDW'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= merge_i && ((cap_i & pending_q) != '0);
      if (accept) begin
        valid_q <= 1'b0;
      end else if (!valid_q && (pending_q != '0)) begin
        valid_q <= 1'b1;
        id_q    <= pick;
      end
    end
  end

  assign sel_valid_o = valid_q;
  assign sel_id_o    = id_q;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: rtl/goods_pio_irq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// goods_pio_irq_ctrl: hardware IRQ servicer for the goods-select PIO.
// Build option GOODS_PIO_RR_ARB_EN (in goods_sel_arb) selects round-robin. Rev 1.0
// ---------------------------------------------------------------------------
module goods_pio_irq_ctrl
  import goods_pio_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int IDW   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [WIDTH-1:0] avm_writedata,
  input  logic [WIDTH-1:0] avm_readdata,
  input  logic             pio_irq,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [IDW-1:0]   sel_id,
  output logic [WIDTH-1:0] goods_level,
  output logic             sel_overrun
);

  state_t           state_q;
  logic [1:0]       addr_q;
  logic             cs_q;
  logic             wn_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] mask_wr;
  logic             merge;

  assign mask_wr = enable ? cfg_mask : '0;
  assign merge   = (state_q == RD_LVL2);

  // Bus outputs are registered alongside the transition, so the named state
  // is the cycle in which its access is on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= PIO_ADDR_DATA;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      wdata_q  <= '0;
      shadow_q <= '0;
      cap_q    <= '0;
      level_q  <= '0;
    end else begin
      addr_q  <= PIO_ADDR_DATA;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q  <= CFG;
            cs_q     <= 1'b1;
            wn_q     <= 1'b0;
            addr_q   <= PIO_ADDR_MASK;
            wdata_q  <= mask_wr;
            shadow_q <= mask_wr;
          end
        end
        CFG: state_q <= enable ? WAIT : IDLE;
        WAIT: begin
          if (!enable || (cfg_mask != shadow_q)) begin
            state_q  <= CFG;
            cs_q     <= 1'b1;
            wn_q     <= 1'b0;
            addr_q   <= PIO_ADDR_MASK;
            wdata_q  <= mask_wr;
            shadow_q <= mask_wr;
          end else if (pio_irq) begin
            state_q <= RD_CAP;
            cs_q    <= 1'b1;
            addr_q  <= PIO_ADDR_CAP;
          end
        end
        RD_CAP: state_q <= RD_CAP2;
        RD_CAP2: begin
          cap_q   <= avm_readdata & shadow_q;
          state_q <= CLR;
          cs_q    <= 1'b1;
          wn_q    <= 1'b0;
          addr_q  <= PIO_ADDR_CAP;
          wdata_q <= '1;
        end
        CLR: begin
          state_q <= RD_LVL;
          cs_q    <= 1'b1;
          addr_q  <= PIO_ADDR_DATA;
        end
        RD_LVL: state_q <= RD_LVL2;
        RD_LVL2: begin
          level_q <= avm_readdata;
          state_q <= WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  goods_sel_arb #(
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) u_arb (
    .clk         (clk),
    .rst_n       (reset_n),
    .merge_i     (merge),
    .cap_i       (cap_q),
    .sel_ready_i (sel_ready),
    .sel_valid_o (sel_valid),
    .sel_id_o    (sel_id),
    .overrun_o   (sel_overrun)
  );

  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wn_q;
  assign avm_writedata  = wdata_q;
  assign goods_level    = level_q;

endmodule
`default_nettype wire
